reg_pipe: RTL and testbench
===========================

// Module: reg_pipe
// PURPOSE
//   Parametrised elastic pipeline register; successor to the fixed 6-bit reset register.
//   Carries a WIDTH-bit word through DEPTH registered stages with valid/ready handshaking.
//   Internal bubbles collapse, stalls back-pressure cleanly, a synchronous flush drops all
//   contents, and an occupancy count is reported.
//   Sits between the password-entry datapath and the compare logic, and between any two
//   stages that need decoupling.
// PARAMETERS
//   WIDTH   6   payload width in bits, >=1
//   DEPTH   2   number of register stages, >=1
// PORTS
//   clock      in   1                     rising-edge clock
//   reset_n    in   1                     asynchronous, active-low reset
//   flush      in   1                     synchronous clear of all stage valids
//   in_valid   in   1                     upstream word present
//   in_data    in   WIDTH                 upstream word
//   in_ready   out  1                     stage 0 can take a word this cycle
//   out_valid  out  1                     last stage holds a word
//   out_data   out  WIDTH                 last-stage word
//   out_ready  in   1                     downstream takes the word this cycle
//   count      out  $clog2(DEPTH+1)       number of occupied stages, 0..DEPTH
//   par_err    out  1                     sticky parity error (REG_PIPE_PARITY_EN only, else tied 0)
// BEHAVIOUR
//   Reset: reset_n low clears every stage immediately, without waiting for a clock edge.
//     All valid bits = 0, all data = 0, out_valid = 0, out_data = 0, count = 0, par_err = 0.
//     Release is synchronous to clock; the first transfer occurs on the first edge after
//     reset_n is high.
//   Per stage i: holds v[i] and d[i].
//     Stage i "moves" when v[i] && ready[i+1].
//     ready[DEPTH] = out_ready.
//     ready[i] = !v[i] || ready[i+1]. This is a combinational ready chain; no skid buffer.
//   Transfer at stage i+1: on each edge, when ready[i+1] holds:
//     d[i+1] <= d[i], v[i+1] <= v[i].
//     Stage 0 captures in_data when in_valid && in_ready.
//   Handshakes:
//     Upstream handshake = in_valid && in_ready. Downstream handshake = out_valid && out_ready.
//     out_data is stable while out_valid && !out_ready.
//   Latency: an empty, unstalled pipe presents a word on out_data DEPTH edges after its
//   handshake. Throughput is 1 word per cycle when out_ready is held high.
//   Full pipe (count == DEPTH) with out_ready = 0: in_ready = 0 and nothing moves.
//   Simultaneous in and out on a full pipe: in_ready = 1 while out_ready = 1, so one word
//   enters, one word leaves, and count is unchanged.
//   count: on each edge, +1 for an upstream handshake, -1 for a downstream handshake,
//   net 0 when both occur. count never exceeds DEPTH and never goes below 0.
//   flush:
//     Has priority over every other event. in_ready is forced to 0 in a flush cycle.
//     On the edge: all v[i] = 0, count = 0, par_err = 0. Data registers are not cleared.
//     A downstream handshake in the flush cycle still counts as consumed for the receiver;
//     the pipe itself simply ends empty.
//   Data is only written when the stage moves or captures, so no data toggling occurs
//   during a stall.
// CONFIGURATION
//   REG_PIPE_PARITY_EN defined:
//     Each stage stores one extra bit, the even parity of in_data computed at capture.
//     At the output, while out_valid is high, a mismatch between the stored bit and
//     ^out_data sets par_err on the next edge.
//     par_err is sticky and clears only on reset or flush. Latency is unchanged.
//   REG_PIPE_PARITY_EN undefined: no parity storage, and par_err is constant 0.
// STRUCTURE
//   Package reg_pkg: the CNT_W(depth) function ($clog2(depth+1)) and the
//   REG_PIPE_DEPTH_MAX = 16 limit, shared with other register blocks.
//   Sub-module reg_pipe_stage: one stage (valid, data, optional parity bit, ready
//   computation). reg_pipe instantiates DEPTH of these in a generate loop and adds the
//   count and par_err logic.
// TESTING
//   1. Reset: WIDTH=6, DEPTH=2. Drive reset_n low mid-cycle while the pipe is full ->
//      out_valid=0 and count=0 immediately, before the next clock edge.
//   2. Streaming: out_ready=1, send 0x01,0x02,0x03 back-to-back -> 0x01 on out_data 2 edges
//      after its handshake, one word per cycle after that, count holds at 2.
//   3. Back-pressure: out_ready=0, send 0x2A, 0x15, 0x3F -> in_ready=0 after 2 words,
//      count=2, out_data holds 0x2A; raise out_ready -> 0x2A then 0x15 delivered in order,
//      0x3F accepted on the same cycle 0x2A leaves.
//   4. Bubble collapse: DEPTH=4, word A, 2 idle cycles, word B, out_ready=0 ->
//      count=2, A and B end in the last two stages, in_ready=1.
//   5. Flush: with count=2, assert flush with in_valid=1 -> in_ready=0 in that cycle,
//      next cycle count=0 and out_valid=0, and the offered word is not taken.
//   6. Parity (macro defined): send 0x07, then force the stored parity bit of the last stage
//      -> par_err=1 on the next edge and stays 1 until flush.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared definitions for the register blocks: occupancy counter width and depth limit.
package reg_pkg;

  localparam int unsigned REG_PIPE_DEPTH_MAX = 16;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int unsigned CNT_W(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic pipeline stage: valid bit, data word and ready computation.
// With REG_PIPE_PARITY_EN defined, the stage also carries a stored parity bit.
module reg_pipe_stage #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
`ifdef REG_PIPE_PARITY_EN
  input  logic             up_par_i,
  output logic             par_o,
`endif
  input  logic             dn_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ready_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  assign ready_o = !valid_q || dn_ready_i;
  // Data only changes when a word actually lands here, so stalls cause no toggling.
  assign load    = ready_o && up_valid_i && !flush_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ready_o) begin
      valid_d = up_valid_i;
    end
    if (load) begin
      data_d = up_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef REG_PIPE_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load) begin
      par_d = up_par_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_o = par_q;
`endif

endmodule

// File: rtl/reg_pipe.sv
// Parametrised elastic pipeline register with occupancy count and synchronous flush.
// Optional REG_PIPE_PARITY_EN adds per-stage parity and a sticky par_err output.
module reg_pipe
  import reg_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [CNT_W(DEPTH)-1:0]   count,
  output logic                      par_err
);

  localparam int unsigned CntW = CNT_W(DEPTH);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;
`endif

  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
`ifdef REG_PIPE_PARITY_EN
    logic             up_par;
`endif

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
`ifdef REG_PIPE_PARITY_EN
      assign up_par   = ^in_data;
`endif
    end else begin : g_body
      assign up_valid = vld[i-1];
      assign up_data  = dat[i-1];
`ifdef REG_PIPE_PARITY_EN
      assign up_par   = par[i-1];
`endif
    end

    reg_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk_i      (clock),
      .rst_ni     (reset_n),
      .flush_i    (flush),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
`ifdef REG_PIPE_PARITY_EN
      .up_par_i   (up_par),
      .par_o      (par[i]),
`endif
      .dn_ready_i (rdy[i+1]),
      .valid_o    (vld[i]),
      .data_o     (dat[i]),
      .ready_o    (rdy[i])
    );
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

  logic            in_hs, out_hs;
  logic [CntW-1:0] count_q, count_d;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_hs && !out_hs) begin
      count_d = count_q + CntW'(1);
    end else if (!in_hs && out_hs) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef REG_PIPE_PARITY_EN
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (flush) begin
      par_err_d = 1'b0;
    end else if (out_valid && (par[DEPTH-1] != ^out_data)) begin
      par_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: directed scenarios plus randomized traffic against a word/position model.
module tb_reg_pipe;

  localparam int unsigned W  = 6;
  localparam int unsigned D2 = 2;
  localparam int unsigned D4 = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready2, out_valid2, par_err2;
  logic [W-1:0] out_data2;
  logic [1:0]   count2;
  logic         in_ready4, out_valid4, par_err4;
  logic [W-1:0] out_data4;
  logic [2:0]   count4;

  int n_checks = 0;
  int n_pass = 0;

  // Model: queue of words in flight, each with its current stage position.
  logic [W-1:0] m_data[$];
  int           m_pos[$];

  always #5 clock = ~clock;

  reg_pipe #(.WIDTH(W), .DEPTH(D2)) dut2 (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready2),
    .out_valid (out_valid2),
    .out_data  (out_data2),
    .out_ready (out_ready),
    .count     (count2),
    .par_err   (par_err2)
  );

  reg_pipe #(.WIDTH(W), .DEPTH(D4)) dut4 (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_ready (out_ready),
    .count     (count4),
    .par_err   (par_err4)
  );

  // A word advances one stage per edge unless the word ahead of it sits directly in front
  // and cannot move; the head leaves from the last stage when the receiver is ready.
  function automatic void model_step(input bit fl, input bit iv, input logic [W-1:0] id,
                                     input bit ordy);
    logic [W-1:0] nd[$];
    int           np[$];
    int           limit;
    int           p;
    bit           take;
    take = !fl && iv && ((m_data.size() < D2) || ordy);
    if (fl) begin
      m_data.delete();
      m_pos.delete();
      return;
    end
    limit = D2 - 1;
    for (int k = 0; k < m_data.size(); k++) begin
      if (k == 0 && m_pos[0] == D2 - 1 && ordy) continue;
      p = (m_pos[k] + 1 < limit) ? m_pos[k] + 1 : limit;
      nd.push_back(m_data[k]);
      np.push_back(p);
      limit = p - 1;
    end
    if (take) begin
      nd.push_back(id);
      np.push_back(0);
    end
    m_data = nd;
    m_pos  = np;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #7;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    m_data.delete();
    m_pos.delete();
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'h11;
    tick();
    in_data = 6'h22;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (count2 !== 2'd2) $display("FAIL reset_prefill_count got %0d expected 2", count2);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid2 !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", out_valid2);
    else n_pass++;
    n_checks++;
    if (count2 !== 2'd0) $display("FAIL reset_count got %0d expected 0", count2);
    else n_pass++;
    n_checks++;
    if (out_data2 !== 6'h00) $display("FAIL reset_out_data got %h expected 00", out_data2);
    else n_pass++;
    n_checks++;
    if (in_ready2 !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready2);
    else n_pass++;
    n_checks++;
    if (par_err2 !== 1'b0) $display("FAIL reset_par_err got %b expected 0", par_err2);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 6'h01;
    #1;
    n_checks++;
    if (in_ready2 !== 1'b1) $display("FAIL stream_in_ready got %b expected 1", in_ready2);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid2 !== 1'b0) $display("FAIL stream_early_valid got %b expected 0", out_valid2);
    else n_pass++;
    in_data = 6'h02;
    tick();
    n_checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 6'h01 || count2 !== 2'd2)
      $display("FAIL stream_word1 got v=%b d=%h c=%0d expected v=1 d=01 c=2",
               out_valid2, out_data2, count2);
    else n_pass++;
    in_data = 6'h03;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 6'h02 || count2 !== 2'd2)
      $display("FAIL stream_word2 got v=%b d=%h c=%0d expected v=1 d=02 c=2",
               out_valid2, out_data2, count2);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 6'h03 || count2 !== 2'd1)
      $display("FAIL stream_word3 got v=%b d=%h c=%0d expected v=1 d=03 c=1",
               out_valid2, out_data2, count2);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid2 !== 1'b0 || count2 !== 2'd0)
      $display("FAIL stream_drain got v=%b c=%0d expected v=0 c=0", out_valid2, count2);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'h2A;
    tick();
    in_data = 6'h15;
    tick();
    in_data = 6'h3F;
    #1;
    n_checks++;
    if (in_ready2 !== 1'b0 || count2 !== 2'd2 || out_data2 !== 6'h2A)
      $display("FAIL bp_full got rdy=%b c=%0d d=%h expected rdy=0 c=2 d=2a",
               in_ready2, count2, out_data2);
    else n_pass++;
    tick();
    n_checks++;
    if (out_data2 !== 6'h2A || count2 !== 2'd2 || out_valid2 !== 1'b1)
      $display("FAIL bp_hold got d=%h c=%0d v=%b expected d=2a c=2 v=1",
               out_data2, count2, out_valid2);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready2 !== 1'b1) $display("FAIL bp_pass_ready got %b expected 1", in_ready2);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_data2 !== 6'h15 || count2 !== 2'd2)
      $display("FAIL bp_second got d=%h c=%0d expected d=15 c=2", out_data2, count2);
    else n_pass++;
    tick();
    n_checks++;
    if (out_data2 !== 6'h3F || out_valid2 !== 1'b1 || count2 !== 2'd1)
      $display("FAIL bp_third got d=%h v=%b c=%0d expected d=3f v=1 c=1",
               out_data2, out_valid2, count2);
    else n_pass++;
    tick();
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'h11;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 6'h22;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (count4 !== 3'd2 || out_valid4 !== 1'b1 || out_data4 !== 6'h11 || in_ready4 !== 1'b1)
      $display("FAIL bubble_collapse got c=%0d v=%b d=%h rdy=%b expected c=2 v=1 d=11 rdy=1",
               count4, out_valid4, out_data4, in_ready4);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid4 !== 1'b1 || out_data4 !== 6'h22 || count4 !== 3'd1)
      $display("FAIL bubble_second got v=%b d=%h c=%0d expected v=1 d=22 c=1",
               out_valid4, out_data4, count4);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'h05;
    tick();
    in_data = 6'h0A;
    tick();
    n_checks++;
    if (count2 !== 2'd2) $display("FAIL flush_prefill got %0d expected 2", count2);
    else n_pass++;
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 6'h3C;
    #1;
    n_checks++;
    if (in_ready2 !== 1'b0) $display("FAIL flush_in_ready got %b expected 0", in_ready2);
    else n_pass++;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (count2 !== 2'd0 || out_valid2 !== 1'b0)
      $display("FAIL flush_empty got c=%0d v=%b expected c=0 v=0", count2, out_valid2);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (out_valid2 !== 1'b0 || count2 !== 2'd0)
      $display("FAIL flush_not_taken got v=%b c=%0d expected v=0 c=0", out_valid2, count2);
    else n_pass++;
  endtask

`ifdef REG_PIPE_PARITY_EN
  task automatic test_parity();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'h07;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (par_err2 !== 1'b0) $display("FAIL parity_clean got %b expected 0", par_err2);
    else n_pass++;
    force dut2.g_stage[1].u_stage.par_q = 1'b0;
    tick();
    release dut2.g_stage[1].u_stage.par_q;
    n_checks++;
    if (par_err2 !== 1'b1) $display("FAIL parity_set got %b expected 1", par_err2);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (par_err2 !== 1'b1) $display("FAIL parity_sticky got %b expected 1", par_err2);
    else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (par_err2 !== 1'b0) $display("FAIL parity_flush got %b expected 0", par_err2);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    int  ready_pct;
    bit  exp_valid;
    bit  exp_ready;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      ready_pct = (cyc < 300) ? 35 : 85;
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clock);
      exp_valid = (m_data.size() > 0) && (m_pos[0] == D2 - 1);
      exp_ready = !flush && ((m_data.size() < D2) || out_ready);
      n_checks++;
      if (in_ready2 !== exp_ready)
        $display("FAIL rand_in_ready cyc %0d got %b expected %b", cyc, in_ready2, exp_ready);
      else n_pass++;
      n_checks++;
      if (out_valid2 !== exp_valid)
        $display("FAIL rand_out_valid cyc %0d got %b expected %b", cyc, out_valid2, exp_valid);
      else n_pass++;
      n_checks++;
      if (count2 !== 2'(m_data.size()))
        $display("FAIL rand_count cyc %0d got %0d expected %0d", cyc, count2, m_data.size());
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (out_data2 !== m_data[0])
          $display("FAIL rand_out_data cyc %0d got %h expected %h", cyc, out_data2, m_data[0]);
        else n_pass++;
      end
      n_checks++;
      if (par_err2 !== 1'b0)
        $display("FAIL rand_par_err cyc %0d got %b expected 0", cyc, par_err2);
      else n_pass++;
      model_step(flush, in_valid, in_data, out_ready);
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
`ifdef REG_PIPE_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
